// File: rtl/day11_core.sv
// day11_core: streams puzzle text from a synchronous ROM, builds the device graph and counts paths.
// Optional feature macro: DAY11_PART2_EN builds the six part-2 queries and the multiply/add combine.
module day11_core #(
  parameter int N_ADDR_BITS       = 16,
  parameter int MAX_NODES         = 1024,
  parameter int MAX_EDGES         = 4096,
  parameter int OUTPUT_DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  // rom_data/rom_valid describe the address presented one edge earlier; rom_valid low marks
  // end of file. There is no back-pressure: the core consumes one byte per PARSE cycle.
  output logic [N_ADDR_BITS:0]         rom_addr,
  input  logic [7:0]                   rom_data,
  input  logic                         rom_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0] part1_result,
  output logic [OUTPUT_DATA_WIDTH-1:0] part2_result,
  output logic                         done
);
  localparam int IW  = $clog2(MAX_NODES);
  localparam int EIW = $clog2(MAX_EDGES);
  localparam int EW  = EIW + 1;
  localparam int OW  = OUTPUT_DATA_WIDTH;
  localparam int TAB = 17576;
`ifdef DAY11_PART2_EN
  localparam int N_QUERY = 7;
`else
  localparam int N_QUERY = 1;
`endif

  localparam logic [N_ADDR_BITS:0] A_ONE    = (N_ADDR_BITS+1)'(1);
  localparam logic [IW:0]          N_ONE    = (IW+1)'(1);
  localparam logic [IW:0]          NODE_CAP = (IW+1)'(MAX_NODES);
  localparam logic [EW-1:0]        E_ONE    = EW'(1);
  localparam logic [EW-1:0]        EDGE_CAP = EW'(MAX_EDGES);

  // Name-table indices, (c0-'a')*676 + (c1-'a')*26 + (c2-'a').
  localparam logic [14:0] YOU = 15'd16608;
  localparam logic [14:0] OUT = 15'd10003;
  localparam logic [14:0] SVR = 15'd12731;
  localparam logic [14:0] DAC = 15'd2030;
  localparam logic [14:0] FFT = 15'd3529;

  typedef enum logic [3:0] {
    CLEAR, PARSE, T_SCAN, T_NODE, T_EDGE,
    Q_SETUP, Q_CLR, Q_NODE, Q_EDGE, Q_END, DONE
  } state_t;

  state_t state;

  logic [IW:0]   name_tab  [TAB];
  logic [IW-1:0] edge_dst  [MAX_EDGES];
  logic [EW-1:0] edge_next [MAX_EDGES];
  logic [EW-1:0] head      [MAX_NODES];  // edge pointer, 0 = end of list
  logic [EW-1:0] indeg     [MAX_NODES];
  logic [IW-1:0] topo      [MAX_NODES];
  logic [OW-1:0] cnt       [MAX_NODES];
  logic [OW-1:0] res       [8];

  logic [14:0]   clr_idx;
  logic [4:0]    c0, c1;
  logic [1:0]    pos;
  logic          at_src, src_ok;
  logic [IW-1:0] src_id;
  logic [IW:0]   n_nodes, scan, qh, qt, p;
  logic [EW-1:0] n_edges, ep;
  logic [2:0]    qi;
  logic [IW-1:0] s_id, t_id;
  logic [OW-1:0] cu;

  function automatic logic [14:0] name_index(input logic [4:0] a, input logic [4:0] b,
                                             input logic [4:0] c);
    return 15'(a) * 15'd676 + 15'(b) * 15'd26 + 15'(c);
  endfunction

  logic          is_letter, name_new, name_ok;
  logic [4:0]    letter;
  logic [14:0]   parse_idx, q_s, q_t;
  logic [IW:0]   parse_entry, s_raw, t_raw;
  logic [IW-1:0] name_id, tu, pu, ev;
  logic [EIW-1:0] eidx;

  always_comb begin
    letter      = 5'(rom_data - 8'd97);
    is_letter   = (rom_data >= 8'd97) && (rom_data <= 8'd122);
    parse_idx   = name_index(c0, c1, letter);
    parse_entry = name_tab[parse_idx];
    name_new    = (parse_entry == '0) && (n_nodes < NODE_CAP);
    name_ok     = (parse_entry != '0) || name_new;
    name_id     = name_new ? n_nodes[IW-1:0] : IW'(parse_entry - N_ONE);
    eidx        = EIW'(ep - E_ONE);
    ev          = edge_dst[eidx];
    tu          = topo[qh[IW-1:0]];
    pu          = topo[p[IW-1:0]];
    q_s = YOU;
    q_t = OUT;
    case (qi)
      3'd1: begin q_s = SVR; q_t = DAC; end
      3'd2: begin q_s = DAC; q_t = FFT; end
      3'd3: begin q_s = FFT; q_t = OUT; end
      3'd4: begin q_s = SVR; q_t = FFT; end
      3'd5: begin q_s = FFT; q_t = DAC; end
      3'd6: begin q_s = DAC; q_t = OUT; end
      default: ;
    endcase
    s_raw = name_tab[q_s];
    t_raw = name_tab[q_t];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      rom_addr     <= '0;
      done         <= 1'b0;
      part1_result <= '0;
      part2_result <= '0;
      c0           <= '0;
      c1           <= '0;
      pos          <= '0;
      at_src       <= 1'b1;
      src_ok       <= 1'b0;
      src_id       <= '0;
      n_nodes      <= '0;
      n_edges      <= '0;
      scan         <= '0;
      qh           <= '0;
      qt           <= '0;
      p            <= '0;
      ep           <= '0;
      qi           <= '0;
      s_id         <= '0;
      t_id         <= '0;
      cu           <= '0;
    end else begin
      case (state)
        CLEAR: begin
          name_tab[clr_idx] <= '0;
          clr_idx <= clr_idx + 15'd1;
          if (clr_idx == 15'(TAB - 1)) begin
            state    <= PARSE;
            rom_addr <= A_ONE;  // address 0 was already sampled by the ROM during CLEAR
          end
        end
        PARSE: begin
          if (!rom_valid) begin
            state <= T_SCAN;
            scan  <= '0;
            qh    <= '0;
            qt    <= '0;
          end else begin
            rom_addr <= rom_addr + A_ONE;
            if (rom_data == 8'h0a) begin
              pos    <= '0;
              at_src <= 1'b1;
            end else if (!is_letter) begin
              pos <= '0;
            end else if (pos == 2'd2) begin
              pos <= '0;
              if (name_new) begin
                name_tab[parse_idx] <= n_nodes + N_ONE;
                n_nodes             <= n_nodes + N_ONE;
                head[name_id]       <= '0;
                indeg[name_id]      <= '0;
              end
              if (at_src) begin
                at_src <= 1'b0;
                src_ok <= name_ok;
                src_id <= name_id;
              end else if (src_ok && name_ok && (n_edges < EDGE_CAP)) begin
                edge_dst[EIW'(n_edges)]  <= name_id;
                edge_next[EIW'(n_edges)] <= head[src_id];
                head[src_id]             <= n_edges + E_ONE;
                n_edges                  <= n_edges + E_ONE;
                indeg[name_id]           <= (name_new ? '0 : indeg[name_id]) + E_ONE;
              end
            end else begin
              if (pos == 2'd0) c0 <= letter;
              else             c1 <= letter;
              pos <= pos + 2'd1;
            end
          end
        end
        // Kahn's algorithm; topo[] doubles as the work queue, so qt ends as the order length.
        T_SCAN: begin
          if (scan == n_nodes) begin
            state <= T_NODE;
          end else begin
            if (indeg[scan[IW-1:0]] == '0) begin
              topo[qt[IW-1:0]] <= scan[IW-1:0];
              qt <= qt + N_ONE;
            end
            scan <= scan + N_ONE;
          end
        end
        T_NODE: begin
          if (qh == qt) begin
            state <= Q_SETUP;
            qi    <= '0;
          end else begin
            ep    <= head[tu];
            qh    <= qh + N_ONE;
            state <= T_EDGE;
          end
        end
        T_EDGE: begin
          if (ep == '0) begin
            state <= T_NODE;
          end else begin
            indeg[ev] <= indeg[ev] - E_ONE;
            if (indeg[ev] == E_ONE) begin
              topo[qt[IW-1:0]] <= ev;
              qt <= qt + N_ONE;
            end
            ep <= edge_next[eidx];
          end
        end
        Q_SETUP: begin
          if ((s_raw == '0) || (t_raw == '0)) begin
            res[qi] <= '0;
            state   <= Q_END;
          end else begin
            s_id  <= IW'(s_raw - N_ONE);
            t_id  <= IW'(t_raw - N_ONE);
            scan  <= '0;
            state <= Q_CLR;
          end
        end
        Q_CLR: begin
          if (scan == n_nodes) begin
            p     <= '0;
            state <= Q_NODE;
          end else begin
            cnt[scan[IW-1:0]] <= {{(OW-1){1'b0}}, (scan[IW-1:0] == s_id)};
            scan <= scan + N_ONE;
          end
        end
        Q_NODE: begin
          if (p == qt) begin
            res[qi] <= cnt[t_id];
            state   <= Q_END;
          end else begin
            cu    <= cnt[pu];
            ep    <= head[pu];
            p     <= p + N_ONE;
            state <= Q_EDGE;
          end
        end
        Q_EDGE: begin
          if (ep == '0) begin
            state <= Q_NODE;
          end else begin
            cnt[ev] <= cnt[ev] + cu;
            ep      <= edge_next[eidx];
          end
        end
        Q_END: begin
          if (qi == 3'(N_QUERY - 1)) begin
            state        <= DONE;
            done         <= 1'b1;
            part1_result <= res[0];
`ifdef DAY11_PART2_EN
            part2_result <= res[1] * res[2] * res[3] + res[4] * res[5] * res[6];
`else
            part2_result <= '0;
`endif
          end else begin
            qi    <= qi + 3'd1;
            state <= Q_SETUP;
          end
        end
        DONE: ;
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_day11_core.sv
// tb_day11_core: directed puzzle texts through a bench ROM; expected results go into a queue
// that a done-edge monitor pops and compares.
`timescale 1ns/1ps
module tb_day11_core;
  localparam int W = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_valid;
  logic [63:0] part1_result, part2_result;
  logic        done;

  logic [7:0] mem [256];
  int         rom_len = 0;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  day11_core dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
    .part1_result(part1_result), .part2_result(part2_result), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous ROM: one cycle read latency
  always @(posedge clk) begin
    rom_valid <= (int'(rom_addr) < rom_len);
    rom_data  <= (int'(rom_addr) < rom_len) ? mem[rom_addr[7:0]] : 8'h00;
  end

  // driver tasks
  task automatic load(input string s);
    rom_len = s.len();
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_part1"}, part1_result, 64'd0);
    check({name, "_part2"}, part2_result, 64'd0);
    check({name, "_rom_addr"}, 64'(rom_addr), 64'd0);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 30000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_done_timeout: done=%0b after %0d cycles, required 1", name, done, n);
    end
    repeat (5) @(negedge clk);
  endtask

  // scoreboard monitor
  logic         done_q = 1'b0;
  logic [63:0]  e1 = '0, e2 = '0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done rose with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        e1 = e[W-1:64];
        e2 = e[63:0];
        check("part1_result", part1_result, e1);
        check("part2_result", part2_result, e2);
      end
    end else if (done && done_q) begin
      check("part1_frozen", part1_result, e1);
      check("part2_frozen", part2_result, e2);
    end
    done_q = done;
  end

  string s_p1, s_p2;
  logic [63:0] p2_expect;

  initial begin
    int n;
    s_p1 = {"aaa: you hhh\nyou: bbb ccc\nbbb: ddd eee\nccc: ddd eee fff\nddd: ggg\n",
            "eee: out\nfff: out\nggg: out\nhhh: ccc fff iii\niii: out\n"};
    // CRLF endings and no final newline
    s_p2 = {"svr: aaa bbb\r\naaa: fft\r\nfft: ccc\r\nbbb: tty\r\ntty: ccc\r\n",
            "ccc: ddd eee\r\nddd: hub\r\nhub: fff\r\neee: dac\r\nfff: ggg hhh\r\n",
            "dac: fff\r\nggg: out\r\nhhh: out"};
`ifdef DAY11_PART2_EN
    p2_expect = 64'd2;
`else
    p2_expect = 64'd0;
`endif

    // part-1 sample, measure CLEAR length, then abort mid-PARSE
    load(s_p1);
    do_reset("reset");
    n = 0;
    while (rom_addr == '0 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clear_cycles", 64'(n), 64'd17576);
    n = 0;
    while (rom_addr < 17'd20 && n < 100) begin
      @(negedge clk);
      n++;
    end
    do_reset("mid_parse_reset");

    // rerun of part-1 sample
    exp_q.push_back({64'd5, 64'd0});
    wait_done("part1_sample");

    // part-2 sample
    load(s_p2);
    exp_q.push_back({64'd0, p2_expect});
    do_reset("reset_p2");
    wait_done("part2_sample");

    // single line
    load("you: out\n");
    exp_q.push_back({64'd1, 64'd0});
    do_reset("reset_single");
    wait_done("single_line");

    // empty ROM
    load("");
    exp_q.push_back({64'd0, 64'd0});
    do_reset("reset_empty");
    wait_done("empty_rom");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
